// File: rtl/cs_pkg.sv
// rtl/cs_pkg.sv - shared widths and FSM state type for the CS block driver
package cs_pkg;

  localparam int X_W     = 8;
  localparam int Y_W     = 10;
  localparam int ADDR_W  = 11;
  localparam int MAX_PAT = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } drv_state_e;

endpackage

// File: rtl/cs_drv_cmp.sv
// rtl/cs_drv_cmp.sv - result comparator: index delay line, golden compare, saturating counters
// CS_DRV_CAPTURE_EN adds first-mismatch index/Y capture registers.
module cs_drv_cmp import cs_pkg::*; #(
  parameter int DUT_LAT    = 1,
  parameter bit NO_ERR_CLR = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_idx_i,
  output logic [ADDR_W-1:0] gold_addr_o,
  input  logic [Y_W-1:0]    gold_data_i,
  input  logic [Y_W-1:0]    y_i,
  output logic [15:0]       err_cnt_o,
  output logic [ADDR_W-1:0] cmp_cnt_o
`ifdef CS_DRV_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] first_err_idx_o,
  output logic [Y_W-1:0]    first_err_y_o
`endif
);

  logic [DUT_LAT:0]  vld_q;
  logic [ADDR_W-1:0] idx_q [DUT_LAT+1];
  logic [15:0]       err_cnt_q;
  logic [ADDR_W-1:0] cmp_cnt_q;
  logic              cmp_fire;
  logic              mism;

  // gold_addr leaves one stage early so the synchronous golden read lines up with Y
  assign gold_addr_o = idx_q[DUT_LAT-1];
  assign cmp_fire    = vld_q[DUT_LAT];
  assign mism        = (y_i !== gold_data_i);
  assign err_cnt_o   = err_cnt_q;
  assign cmp_cnt_o   = cmp_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q     <= '0;
      err_cnt_q <= '0;
      cmp_cnt_q <= '0;
      for (int i = 0; i <= DUT_LAT; i++) idx_q[i] <= '0;
    end else if (clr_i) begin
      vld_q     <= '0;
      cmp_cnt_q <= '0;
      if (!NO_ERR_CLR) err_cnt_q <= '0;
    end else begin
      vld_q <= {vld_q[DUT_LAT-1:0], push_i};
      if (push_i) idx_q[0] <= push_idx_i;
      for (int i = 1; i <= DUT_LAT; i++) idx_q[i] <= idx_q[i-1];
      if (cmp_fire) begin
        cmp_cnt_q <= cmp_cnt_q + 1'b1;
        if (mism && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

`ifdef CS_DRV_CAPTURE_EN
  logic              cap_vld_q;
  logic [ADDR_W-1:0] cap_idx_q;
  logic [Y_W-1:0]    cap_y_q;

  assign first_err_idx_o = cap_idx_q;
  assign first_err_y_o   = cap_y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      cap_y_q   <= '0;
    end else if (clr_i) begin
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
      cap_y_q   <= '0;
    end else if (cmp_fire && mism && !cap_vld_q) begin
      cap_vld_q <= 1'b1;
      cap_idx_q <= idx_q[DUT_LAT];
      cap_y_q   <= y_i;
    end
  end
`endif

endmodule

// File: rtl/cs_driver.sv
// rtl/cs_driver.sv - streams pattern samples into a CS block and scores its results
// CS_DRV_CAPTURE_EN adds first_err_idx/first_err_y outputs.
module cs_driver import cs_pkg::*; #(
  parameter int N_PAT      = 2000,
  parameter int WIN        = 9,
  parameter int DUT_LAT    = 1,
  parameter bit NO_ERR_CLR = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [X_W-1:0]    in_data,
  output logic [ADDR_W-1:0] gold_addr,
  input  logic [Y_W-1:0]    gold_data,
  output logic [X_W-1:0]    X,
  input  logic [Y_W-1:0]    Y,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] cmp_cnt
`ifdef CS_DRV_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic [Y_W-1:0]    first_err_y
`endif
);

  if (N_PAT < 1 || N_PAT > MAX_PAT) begin : g_bad_npat
    $error("cs_driver: N_PAT must lie in 1..2048");
  end
  if (WIN < 1 || WIN > N_PAT || DUT_LAT < 1) begin : g_bad_win
    $error("cs_driver: need 1 <= WIN <= N_PAT and DUT_LAT >= 1");
  end

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N_PAT - 1);
  localparam logic [ADDR_W-1:0] FIRST_CMP  = ADDR_W'(WIN - 1);
  localparam int                DW         = $clog2(DUT_LAT + 1) + 1;
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(DUT_LAT);

  drv_state_e        state_q;
  logic [ADDR_W-1:0] in_addr_q;
  logic [ADDR_W-1:0] x_idx_q;
  logic [X_W-1:0]    x_q;
  logic              busy_q;
  logic              done_q;
  logic [DW-1:0]     drain_q;
  logic              start_acc;
  logic              push;

  assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // a comparison is launched on the same edge that drives its last window sample
  assign push      = (state_q == S_STREAM) && (x_idx_q >= FIRST_CMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      in_addr_q <= '0;
      x_idx_q   <= '0;
      x_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drain_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_PRIME;
            in_addr_q <= '0;
            x_idx_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        S_PRIME: begin
          state_q <= S_STREAM;
          if (in_addr_q != LAST_IDX) in_addr_q <= in_addr_q + 1'b1;
        end
        S_STREAM: begin
          x_q <= in_data;
          if (in_addr_q != LAST_IDX) in_addr_q <= in_addr_q + 1'b1;
          if (x_idx_q == LAST_IDX) begin
            state_q <= S_DRAIN;
            drain_q <= '0;
          end else begin
            x_idx_q <= x_idx_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_addr = in_addr_q;
  assign X       = x_q;
  assign busy    = busy_q;
  assign done    = done_q;

  cs_drv_cmp #(
    .DUT_LAT    (DUT_LAT),
    .NO_ERR_CLR (NO_ERR_CLR)
  ) u_cmp (
    .clk             (clk),
    .reset           (reset),
    .clr_i           (start_acc),
    .push_i          (push),
    .push_idx_i      (x_idx_q - FIRST_CMP),
    .gold_addr_o     (gold_addr),
    .gold_data_i     (gold_data),
    .y_i             (Y),
    .err_cnt_o       (err_cnt),
    .cmp_cnt_o       (cmp_cnt)
`ifdef CS_DRV_CAPTURE_EN
    ,
    .first_err_idx_o (first_err_idx),
    .first_err_y_o   (first_err_y)
`endif
  );

endmodule
